// File: rtl/csr_regfile.sv
// Machine-mode CSR storage: read mux, write commit, trap/mret state,
// 64-bit cycle/instret counters and registered interrupt-pending detection.
module csr_regfile #(
    parameter logic [31:0] HART_ID     = 32'd0,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter int unsigned MAX_BIT_POS = 31
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [11:0]          csr_raddr,
    output logic [MAX_BIT_POS:0] csr_rdata,
    input  logic                 csr_out_en,
    input  logic [11:0]          csrw_addr,
    input  logic [MAX_BIT_POS:0] csrw_data,
    input  logic                 inst_retire,
    input  logic                 trap_en,
    input  logic [31:0]          trap_cause,
    input  logic [31:0]          trap_pc,
    input  logic [31:0]          trap_val,
    input  logic                 mret_en,
    input  logic                 ext_irq,
    input  logic                 timer_irq,
    input  logic                 sw_irq,
    output logic [31:0]          trap_vector,
    output logic [31:0]          mepc_out,
    output logic                 irq_pending,
    output logic                 illegal_csr
);

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MISA      = 12'h301;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MTVAL     = 12'h343;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_CYCLE     = 12'hC00;
    localparam logic [11:0] A_INSTRET   = 12'hC02;
    localparam logic [11:0] A_CYCLEH    = 12'hC80;
    localparam logic [11:0] A_INSTRETH  = 12'hC82;
    localparam logic [11:0] A_MVENDORID = 12'hF11;
    localparam logic [11:0] A_MARCHID   = 12'hF12;
    localparam logic [11:0] A_MIMPID    = 12'hF13;
    localparam logic [11:0] A_MHARTID   = 12'hF14;

    localparam logic [31:0] MISA_VALUE  = 32'h4000_0100;

    logic        mstatus_mie_q;
    logic        mstatus_mpie_q;
    logic [2:0]  mie_q;          // {MEIE, MTIE, MSIE}
    logic [2:0]  mip_q;          // {MEIP, MTIP, MSIP}
    logic [31:0] mtvec_q;
    logic [31:0] mscratch_q;
    logic [31:0] mepc_q;
    logic [31:0] mcause_q;
    logic [31:0] mtval_q;
    logic [63:0] mcycle_q;
    logic [63:0] minstret_q;

    logic [31:0] mstatus_val;
    logic [31:0] mie_val;
    logic [31:0] mip_val;
    logic [31:0] rdata;
    logic        rd_valid;
    logic        wr_writable;
    logic        csr_we;
    logic [31:0] tvec_base;

    assign mstatus_val = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
    assign mie_val     = {20'b0, mie_q[2], 3'b0, mie_q[1], 3'b0, mie_q[0], 3'b0};
    assign mip_val     = {20'b0, mip_q[2], 3'b0, mip_q[1], 3'b0, mip_q[0], 3'b0};

    always_comb begin
        rdata    = '0;
        rd_valid = 1'b1;
        case (csr_raddr)
            A_MSTATUS:                        rdata = mstatus_val;
            A_MISA:                           rdata = MISA_VALUE;
            A_MIE:                            rdata = mie_val;
            A_MTVEC:                          rdata = mtvec_q;
            A_MSCRATCH:                       rdata = mscratch_q;
            A_MEPC:                           rdata = mepc_q;
            A_MCAUSE:                         rdata = mcause_q;
            A_MTVAL:                          rdata = mtval_q;
            A_MIP:                            rdata = mip_val;
            A_MCYCLE, A_CYCLE:                rdata = mcycle_q[31:0];
            A_MCYCLEH, A_CYCLEH:              rdata = mcycle_q[63:32];
            A_MINSTRET, A_INSTRET:            rdata = minstret_q[31:0];
            A_MINSTRETH, A_INSTRETH:          rdata = minstret_q[63:32];
            A_MVENDORID, A_MARCHID, A_MIMPID: rdata = '0;
            A_MHARTID:                        rdata = HART_ID;
            default:                          rd_valid = 1'b0;
        endcase
    end

    always_comb begin
        wr_writable = 1'b0;
        case (csrw_addr)
            A_MSTATUS, A_MIE, A_MTVEC, A_MSCRATCH, A_MEPC, A_MCAUSE, A_MTVAL,
            A_MCYCLE, A_MCYCLEH, A_MINSTRET, A_MINSTRETH: wr_writable = 1'b1;
            default:                                       wr_writable = 1'b0;
        endcase
    end

    // Trap and mret outrank the CSR write, which is then dropped entirely.
    assign csr_we      = csr_out_en && !trap_en && !mret_en && wr_writable;
    assign csr_rdata   = rdata;
    assign illegal_csr = !rd_valid || (csr_out_en && !wr_writable);
    assign mepc_out    = mepc_q;
    assign irq_pending = mstatus_mie_q && |(mie_q & mip_q);

    assign tvec_base   = {mtvec_q[31:2], 2'b00};
    assign trap_vector = (mtvec_q[0] && trap_cause[31])
                       ? tvec_base + {25'b0, trap_cause[4:0], 2'b00}
                       : tvec_base;

    always_ff @(posedge clk) begin
        if (!rst) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= '0;
            mip_q          <= '0;
            mtvec_q        <= MTVEC_RESET & ~32'h2;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
        end else begin
            mip_q <= {ext_irq, timer_irq, sw_irq};
            if (trap_en) begin
                mepc_q         <= trap_pc & ~32'h1;
                mcause_q       <= trap_cause;
                mtval_q        <= trap_val;
                mstatus_mpie_q <= mstatus_mie_q;
                mstatus_mie_q  <= 1'b0;
            end else if (mret_en) begin
                mstatus_mie_q  <= mstatus_mpie_q;
                mstatus_mpie_q <= 1'b1;
            end else if (csr_we) begin
                case (csrw_addr)
                    A_MSTATUS: begin
                        mstatus_mie_q  <= csrw_data[3];
                        mstatus_mpie_q <= csrw_data[7];
                    end
                    A_MIE:      mie_q      <= {csrw_data[11], csrw_data[7], csrw_data[3]};
                    A_MTVEC:    mtvec_q    <= csrw_data & ~32'h2;
                    A_MSCRATCH: mscratch_q <= csrw_data;
                    A_MEPC:     mepc_q     <= csrw_data & ~32'h1;
                    A_MCAUSE:   mcause_q   <= csrw_data;
                    A_MTVAL:    mtval_q    <= csrw_data;
                    default: ;
                endcase
            end
        end
    end

    // A write to either counter half suppresses that cycle's increment for the whole counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            if (csr_we && csrw_addr == A_MCYCLE) begin
                mcycle_q[31:0] <= csrw_data;
            end else if (csr_we && csrw_addr == A_MCYCLEH) begin
                mcycle_q[63:32] <= csrw_data;
            end else begin
                mcycle_q <= mcycle_q + 64'd1;
            end

            if (csr_we && csrw_addr == A_MINSTRET) begin
                minstret_q[31:0] <= csrw_data;
            end else if (csr_we && csrw_addr == A_MINSTRETH) begin
                minstret_q[63:32] <= csrw_data;
            end else if (inst_retire) begin
                minstret_q <= minstret_q + 64'd1;
            end
        end
    end

endmodule

// File: tb/tb_csr_regfile.sv
// Directed and randomized checks of csr_regfile against an address-keyed
// behavioural CSR model with 64-bit counters.
module tb_csr_regfile;

    localparam logic [31:0] HART       = 32'd3;
    localparam logic [31:0] MTVEC_RST  = 32'h0000_0100;

    logic        clk;
    logic        rst;
    logic [11:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic        csr_out_en;
    logic [11:0] csrw_addr;
    logic [31:0] csrw_data;
    logic        inst_retire;
    logic        trap_en;
    logic [31:0] trap_cause;
    logic [31:0] trap_pc;
    logic [31:0] trap_val;
    logic        mret_en;
    logic        ext_irq;
    logic        timer_irq;
    logic        sw_irq;
    logic [31:0] trap_vector;
    logic [31:0] mepc_out;
    logic        irq_pending;
    logic        illegal_csr;

    csr_regfile #(
        .HART_ID     (HART),
        .MTVEC_RESET (MTVEC_RST),
        .MAX_BIT_POS (31)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .csr_raddr   (csr_raddr),
        .csr_rdata   (csr_rdata),
        .csr_out_en  (csr_out_en),
        .csrw_addr   (csrw_addr),
        .csrw_data   (csrw_data),
        .inst_retire (inst_retire),
        .trap_en     (trap_en),
        .trap_cause  (trap_cause),
        .trap_pc     (trap_pc),
        .trap_val    (trap_val),
        .mret_en     (mret_en),
        .ext_irq     (ext_irq),
        .timer_irq   (timer_irq),
        .sw_irq      (sw_irq),
        .trap_vector (trap_vector),
        .mepc_out    (mepc_out),
        .irq_pending (irq_pending),
        .illegal_csr (illegal_csr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: storage CSRs keyed by address, counters as 64-bit values.
    logic [31:0] regs [logic [11:0]];
    logic [63:0] m_cycle;
    logic [63:0] m_instret;
    logic [31:0] m_mip;

    logic [11:0] addrs [0:26] = '{
        12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
        12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02,
        12'hC82, 12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h000, 12'h345, 12'h7C0,
        12'hC01, 12'hB03, 12'hF15
    };

    function automatic bit writable(input logic [11:0] a);
        case (a)
            12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
            12'hB00, 12'hB80, 12'hB02, 12'hB82: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] wmask(input logic [11:0] a);
        case (a)
            12'h300: return 32'h0000_0088;
            12'h304: return 32'h0000_0888;
            12'h305: return 32'hFFFF_FFFD;
            12'h341: return 32'hFFFF_FFFE;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    // {illegal, data}
    function automatic logic [32:0] exp_read(input logic [11:0] a);
        case (a)
            12'h301:          return {1'b0, 32'h4000_0100};
            12'h344:          return {1'b0, m_mip};
            12'hB00, 12'hC00: return {1'b0, m_cycle[31:0]};
            12'hB80, 12'hC80: return {1'b0, m_cycle[63:32]};
            12'hB02, 12'hC02: return {1'b0, m_instret[31:0]};
            12'hB82, 12'hC82: return {1'b0, m_instret[63:32]};
            12'hF11, 12'hF12, 12'hF13: return {1'b0, 32'h0};
            12'hF14:          return {1'b0, HART};
            default: begin
                if (regs.exists(a)) return {1'b0, regs[a]};
                return {1'b1, 32'h0};
            end
        endcase
    endfunction

    task automatic model_reset();
        regs.delete();
        regs[12'h300] = 32'h0000_1800;
        regs[12'h304] = 32'h0;
        regs[12'h305] = MTVEC_RST & ~32'h2;
        regs[12'h340] = 32'h0;
        regs[12'h341] = 32'h0;
        regs[12'h342] = 32'h0;
        regs[12'h343] = 32'h0;
        m_cycle   = 64'd0;
        m_instret = 64'd0;
        m_mip     = 32'h0;
    endtask

    task automatic model_edge();
        logic [31:0] ms;
        bit cyc_wr, ins_wr;
        if (!rst) begin
            model_reset();
            return;
        end
        ms = regs[12'h300];
        cyc_wr = 1'b0;
        ins_wr = 1'b0;
        if (trap_en) begin
            regs[12'h341] = trap_pc & ~32'h1;
            regs[12'h342] = trap_cause;
            regs[12'h343] = trap_val;
            regs[12'h300] = 32'h1800 | (ms[3] ? 32'h80 : 32'h0);
        end else if (mret_en) begin
            regs[12'h300] = 32'h1880 | (ms[7] ? 32'h8 : 32'h0);
        end else if (csr_out_en && writable(csrw_addr)) begin
            case (csrw_addr)
                12'hB00: begin m_cycle   = {m_cycle[63:32], csrw_data};   cyc_wr = 1'b1; end
                12'hB80: begin m_cycle   = {csrw_data, m_cycle[31:0]};    cyc_wr = 1'b1; end
                12'hB02: begin m_instret = {m_instret[63:32], csrw_data}; ins_wr = 1'b1; end
                12'hB82: begin m_instret = {csrw_data, m_instret[31:0]};  ins_wr = 1'b1; end
                default: regs[csrw_addr] = (csrw_data & wmask(csrw_addr))
                                         | (csrw_addr == 12'h300 ? 32'h1800 : 32'h0);
            endcase
        end
        if (!cyc_wr) m_cycle = m_cycle + 64'd1;
        if (!ins_wr && inst_retire) m_instret = m_instret + 64'd1;
        m_mip = (ext_irq ? 32'h800 : 32'h0) | (timer_irq ? 32'h80 : 32'h0) | (sw_irq ? 32'h8 : 32'h0);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic check_all(input string tag);
        logic [32:0] r;
        logic [31:0] mt, tv;
        logic        ill;
        r   = exp_read(csr_raddr);
        ill = r[32] | (csr_out_en & !writable(csrw_addr));
        mt  = regs[12'h305];
        tv  = mt & ~32'h3;
        if (mt[0] && trap_cause[31]) tv = tv + 32'd4 * (trap_cause & 32'h1F);
        chk({tag, ":rdata"}, csr_rdata, r[31:0]);
        chk({tag, ":illegal"}, {31'b0, illegal_csr}, {31'b0, ill});
        chk({tag, ":trap_vector"}, trap_vector, tv);
        chk({tag, ":mepc_out"}, mepc_out, regs[12'h341]);
        chk({tag, ":irq_pending"}, {31'b0, irq_pending},
            {31'b0, regs[12'h300][3] && ((regs[12'h304] & m_mip) != 0)});
    endtask

    // sel: 0 none, 1 constant rdata, 2 constant trap_vector
    task automatic cyc(input string tag, input bit do_chk, input int sel, input logic [31:0] xv);
        @(negedge clk);
        if (do_chk) check_all(tag);
        if (sel == 1) chk({tag, ":const_rdata"}, csr_rdata, xv);
        if (sel == 2) chk({tag, ":const_tvec"}, trap_vector, xv);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic clr();
        csr_raddr   = 12'h0;
        csr_out_en  = 1'b0;
        csrw_addr   = 12'h0;
        csrw_data   = 32'h0;
        inst_retire = 1'b0;
        trap_en     = 1'b0;
        trap_cause  = 32'h0;
        trap_pc     = 32'h0;
        trap_val    = 32'h0;
        mret_en     = 1'b0;
        ext_irq     = 1'b0;
        timer_irq   = 1'b0;
        sw_irq      = 1'b0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        csr_out_en = 1'b1;
        csrw_addr  = a;
        csrw_data  = d;
    endtask

    initial begin
        model_reset();
        clr();
        rst = 1'b0;
        cyc("pre", 1'b0, 0, 32'h0);
        cyc("in_rst", 1'b1, 0, 32'h0);
        rst = 1'b1;

        clr(); csr_raddr = 12'hB00; cyc("rst_mcycle", 1'b1, 1, 32'h0);
        clr(); csr_raddr = 12'h300; cyc("rst_mstatus", 1'b1, 1, 32'h1800);
        clr(); csr_raddr = 12'h305; cyc("rst_mtvec", 1'b1, 1, MTVEC_RST);
        clr(); csr_raddr = 12'hF14; cyc("mhartid", 1'b1, 1, HART);

        clr(); wr(12'h340, 32'hDEADBEEF); csr_raddr = 12'h340; cyc("mscratch_rdw", 1'b1, 1, 32'h0);
        clr(); csr_raddr = 12'h340; cyc("mscratch_rd", 1'b1, 1, 32'hDEADBEEF);
        clr(); wr(12'h301, 32'hFFFF_FFFF); csr_raddr = 12'h301; cyc("misa_wr", 1'b1, 1, 32'h4000_0100);
        clr(); csr_raddr = 12'h301; cyc("misa_rd", 1'b1, 1, 32'h4000_0100);

        clr(); wr(12'h300, 32'h8); cyc("set_mie", 1'b1, 0, 32'h0);
        clr(); wr(12'h305, 32'h1001); cyc("set_mtvec", 1'b1, 0, 32'h0);
        clr(); trap_en = 1'b1; trap_pc = 32'h103; trap_cause = 32'h8000_000B; trap_val = 32'h55;
        csr_raddr = 12'h300; cyc("trap_vec", 1'b1, 2, 32'h102C);
        clr(); csr_raddr = 12'h341; cyc("trap_mepc", 1'b1, 1, 32'h102);
        clr(); csr_raddr = 12'h300; cyc("trap_mstatus", 1'b1, 1, 32'h1880);
        clr(); mret_en = 1'b1; csr_raddr = 12'h300; cyc("mret", 1'b1, 0, 32'h0);
        clr(); csr_raddr = 12'h300; cyc("mret_mstatus", 1'b1, 1, 32'h1888);

        clr(); trap_en = 1'b1; trap_pc = 32'h2001; trap_cause = 32'h2; wr(12'h341, 32'h500);
        cyc("trap_vs_wr", 1'b1, 2, 32'h1000);
        clr(); csr_raddr = 12'h341; cyc("trap_vs_wr_mepc", 1'b1, 1, 32'h2000);

        clr(); wr(12'hB00, 32'hFFFF_FFFF); cyc("mcycle_lo", 1'b1, 0, 32'h0);
        clr(); wr(12'hB80, 32'h0); cyc("mcycle_hi", 1'b1, 0, 32'h0);
        clr(); csr_raddr = 12'hB00; cyc("mcycle_pre", 1'b1, 1, 32'hFFFF_FFFF);
        clr(); csr_raddr = 12'hB00; cyc("mcycle_wrap", 1'b1, 1, 32'h0);
        clr(); csr_raddr = 12'hB80; cyc("mcycle_carry", 1'b1, 1, 32'h1);
        clr(); wr(12'hB02, 32'h5); inst_retire = 1'b1; cyc("minstret_wr", 1'b1, 0, 32'h0);
        clr(); csr_raddr = 12'hB02; cyc("minstret_rd", 1'b1, 1, 32'h5);

        clr(); wr(12'h304, 32'h800); cyc("mie_wr", 1'b1, 0, 32'h0);
        clr(); wr(12'h300, 32'h8); cyc("mie_bit", 1'b1, 0, 32'h0);
        clr(); ext_irq = 1'b1; csr_raddr = 12'h344; cyc("irq_raise", 1'b1, 1, 32'h0);
        clr(); ext_irq = 1'b1; csr_raddr = 12'h344; cyc("irq_seen", 1'b1, 1, 32'h800);

        clr(); rst = 1'b0; csr_raddr = 12'h340; cyc("rst_mid", 1'b1, 1, 32'hDEADBEEF);
        clr(); rst = 1'b1; csr_raddr = 12'h340; cyc("rst_mid_after", 1'b1, 1, 32'h0);

        for (int i = 0; i < 400; i++) begin
            clr();
            rst       = ($urandom_range(0, 59) != 0);
            csr_raddr = addrs[$urandom_range(0, 26)];
            if ($urandom_range(0, 2) == 0) wr(addrs[$urandom_range(0, 26)], $urandom);
            if ($urandom_range(0, 11) == 0) begin
                trap_en = 1'b1;
                trap_pc = $urandom;
                trap_val = $urandom;
            end
            trap_cause  = $urandom & 32'h8000_001F;
            mret_en     = ($urandom_range(0, 11) == 0);
            inst_retire = $urandom_range(0, 1) == 1;
            ext_irq     = $urandom_range(0, 1) == 1;
            timer_irq   = $urandom_range(0, 1) == 1;
            sw_irq      = $urandom_range(0, 1) == 1;
            cyc("rand", 1'b1, 0, 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
